// File: rtl/y_quant_8x8_if.sv
// Block-level bus for the luminance quantizer: full 8x8 coefficient block in, quantized block out.
interface y_quant_8x8_if;
  logic              enable;
  logic signed [10:0] Z [0:7][0:7];
  logic signed [10:0] Q [0:7][0:7];
  logic              out_enable;

  modport master (output enable, output Z, input Q, input out_enable);
  modport slave  (input enable, input Z, output Q, output out_enable);
endinterface

// File: rtl/y_quant_8x8.sv
// JPEG luminance quantizer: 64 parallel reciprocal multiplies, then a rounding shift; 2-cycle latency.
// Build option: define Y_QUANT_ROUNDING_EN for round-half-up, otherwise results are floored.
module y_quant_8x8 (
  input  logic           clk,
  input  logic           rst,
  y_quant_8x8_if.slave   bus
);
  typedef logic        [0:7][0:7][6:0]  qt_tab_t;
  typedef logic        [0:7][0:7][11:0] recip_tab_t;
  typedef logic signed [23:0]           prod_t;

  localparam qt_tab_t QT = '{
    '{7'd16, 7'd11, 7'd10, 7'd16, 7'd24,  7'd40,  7'd51,  7'd61},
    '{7'd12, 7'd12, 7'd14, 7'd19, 7'd26,  7'd58,  7'd60,  7'd55},
    '{7'd14, 7'd13, 7'd16, 7'd24, 7'd40,  7'd57,  7'd69,  7'd56},
    '{7'd14, 7'd17, 7'd22, 7'd29, 7'd51,  7'd87,  7'd80,  7'd62},
    '{7'd18, 7'd22, 7'd37, 7'd56, 7'd68,  7'd109, 7'd103, 7'd77},
    '{7'd24, 7'd35, 7'd55, 7'd64, 7'd81,  7'd104, 7'd113, 7'd92},
    '{7'd49, 7'd64, 7'd78, 7'd87, 7'd103, 7'd121, 7'd120, 7'd101},
    '{7'd72, 7'd92, 7'd95, 7'd98, 7'd112, 7'd100, 7'd103, 7'd99}
  };

  // Division becomes a multiply by round(4096/qt); evaluated at elaboration only.
  function automatic recip_tab_t build_recip(qt_tab_t qt);
    recip_tab_t r;
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 8; j++) begin
        int q;
        q       = int'(qt[i][j]);
        r[i][j] = 12'((4096 + q / 2) / q);
      end
    end
    return r;
  endfunction

  localparam recip_tab_t RECIP = build_recip(QT);

`ifdef Y_QUANT_ROUNDING_EN
  localparam prod_t BIAS = 24'sd2048;
`else
  localparam prod_t BIAS = 24'sd0;
`endif

  prod_t p [0:7][0:7];
  logic  valid1;

  // NOTE: the product array is 64 ordinary pipeline flops, not a RAM, so it is reset like any register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid1 <= 1'b0;
      for (int i = 0; i < 8; i++)
        for (int j = 0; j < 8; j++)
          p[i][j] <= '0;
    end else begin
      // NOTE: non-blocking so stage 2 sees last cycle's products, not the ones being written now.
      valid1 <= bus.enable;
      if (bus.enable) begin
        for (int i = 0; i < 8; i++)
          for (int j = 0; j < 8; j++)
            p[i][j] <= prod_t'(bus.Z[i][j]) * prod_t'({12'd0, RECIP[i][j]});
      end
    end
  end

  // |Q| never exceeds 103, so dropping the upper bits after the shift loses nothing.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.out_enable <= 1'b0;
      for (int i = 0; i < 8; i++)
        for (int j = 0; j < 8; j++)
          bus.Q[i][j] <= '0;
    end else begin
      bus.out_enable <= valid1;
      if (valid1) begin
        for (int i = 0; i < 8; i++)
          for (int j = 0; j < 8; j++)
            bus.Q[i][j] <= 11'((p[i][j] + BIAS) >>> 12);
      end
    end
  end
endmodule

// File: tb/tb_y_quant_8x8.sv
// Directed bench for y_quant_8x8; expectations follow whichever rounding build is compiled.
module tb_y_quant_8x8;
  typedef logic signed [10:0] blk_t [0:7][0:7];

`ifdef Y_QUANT_ROUNDING_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  blk_t zero_b, grad, x1, x2, x3;

  always #5 clk = ~clk;

  y_quant_8x8_if bus ();
  y_quant_8x8 dut (.clk(clk), .rst(rst), .bus(bus));

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int count_nz();
    int n = 0;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++)
        if (bus.Q[i][j] !== 11'sd0) n++;
    return n;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int k;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++)
        zero_b[i][j] = '0;
    k = 0;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) begin
        if (i + j < 7) begin
          grad[i][j] = 11'(100 + k);
          k++;
        end else if (i + j == 7) begin
          grad[i][j] = 11'sd50;
        end else begin
          grad[i][j] = 11'((i + j) % 3 - 1);
        end
      end
    x1 = zero_b; x1[0][0] = 11'sd1023;  x1[0][1] = 11'sd101; x1[7][7] = -11'sd1;
    x2 = zero_b; x2[0][0] = -11'sd1024; x2[7][7] = -11'sd1024;
    x3 = zero_b; x3[0][0] = -11'sd1;

    // Held in reset with enable toggling: nothing may emerge.
    rst        = 1'b0;
    bus.enable = 1'b0;
    bus.Z      = x1;
    for (int c = 0; c < 4; c++) begin
      bus.enable = (c % 2 == 0);
      step();
      check("rst_hold_oe", int'(bus.out_enable), 0);
      check("rst_hold_q_nz", count_nz(), 0);
    end
    rst        = 1'b1;
    bus.enable = 1'b0;
    step();

    // Gradient block, single pulse: latency and selected coefficients.
    bus.Z      = grad;
    bus.enable = 1'b1;
    step();
    bus.enable = 1'b0;
    check("grad_oe_edge1", int'(bus.out_enable), 0);
    step();
    check("grad_oe_edge2", int'(bus.out_enable), 1);
    check("grad_q00", int'(bus.Q[0][0]), 6);
    check("grad_q01", int'(bus.Q[0][1]), 9);
    check("grad_q07", int'(bus.Q[0][7]), RND ? 1 : 0);
    check("grad_q70", int'(bus.Q[7][0]), RND ? 1 : 0);
    check("grad_q77", int'(bus.Q[7][7]), 0);
    step();
    check("grad_oe_edge3", int'(bus.out_enable), 0);
    check("grad_q00_hold", int'(bus.Q[0][0]), 6);

    // Back-to-back extremes: A = x1, B = x2.
    bus.Z      = x1;
    bus.enable = 1'b1;
    step();
    bus.Z = x2;
    check("b2b_oe_first_edge", int'(bus.out_enable), 0);
    step();
    bus.enable = 1'b0;
    bus.Z      = zero_b;
    check("b2b_a_oe", int'(bus.out_enable), 1);
    check("b2b_a_q00_max", int'(bus.Q[0][0]), RND ? 64 : 63);
    check("b2b_a_q01", int'(bus.Q[0][1]), 9);
    check("b2b_a_q77_neg1", int'(bus.Q[7][7]), RND ? 0 : -1);
    step();
    check("b2b_b_oe", int'(bus.out_enable), 1);
    check("b2b_b_q00_min", int'(bus.Q[0][0]), -64);
    check("b2b_b_q01", int'(bus.Q[0][1]), 0);
    check("b2b_b_q77", int'(bus.Q[7][7]), RND ? -10 : -11);
    step();
    check("b2b_oe_drop", int'(bus.out_enable), 0);
    step();
    step();
    check("b2b_hold_q00", int'(bus.Q[0][0]), -64);
    check("b2b_hold_q77", int'(bus.Q[7][7]), RND ? -10 : -11);

    // Small negative at the top-left: rounding vs floor.
    bus.Z      = x3;
    bus.enable = 1'b1;
    step();
    bus.enable = 1'b0;
    step();
    check("neg1_oe", int'(bus.out_enable), 1);
    check("neg1_q00", int'(bus.Q[0][0]), RND ? 0 : -1);

    // Reset asserted the cycle after enable: the block is dropped.
    bus.Z      = x1;
    bus.enable = 1'b1;
    step();
    rst        = 1'b0;
    bus.enable = 1'b0;
    step();
    check("midrst_oe_a", int'(bus.out_enable), 0);
    check("midrst_q_nz_a", count_nz(), 0);
    step();
    check("midrst_oe_b", int'(bus.out_enable), 0);
    rst = 1'b1;
    step();
    check("postrst_oe_idle", int'(bus.out_enable), 0);
    check("postrst_q_nz", count_nz(), 0);

    // First block after release arrives two edges later.
    bus.Z      = x2;
    bus.enable = 1'b1;
    step();
    bus.enable = 1'b0;
    check("postrst_oe_edge1", int'(bus.out_enable), 0);
    step();
    check("postrst_oe_edge2", int'(bus.out_enable), 1);
    check("postrst_q00", int'(bus.Q[0][0]), -64);
    step();
    check("postrst_oe_edge3", int'(bus.out_enable), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
